// File: rtl/stop_capture_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stop_capture_pkg
//  Purpose  : Shared defaults for the stop-pulse capture FIFO.
//             DEF_WIDTH : width of a captured counter value
//             DEF_DEPTH : FIFO entries (power of two, >= 2)
//             DEF_CNT_W : width of the saturating capture total
//             DEF_PTR_W : FIFO pointer width derived from DEF_DEPTH
//  Revision : 1.0  initial release
// ============================================================================
package stop_capture_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_PTR_W = $clog2(DEF_DEPTH);

endpackage : stop_capture_pkg
`default_nettype wire

// File: rtl/stop_capture_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock show-ahead FIFO. The head entry is presented
//             straight from storage. A push into a full FIFO is accepted only
//             when a pop happens on the same edge (occupancy unchanged).
//  Ports    : clk        - clock, rising edge
//             reset      - synchronous active-high reset
//             push       - write push_data this cycle
//             push_data  - value to write
//             pop        - remove head this cycle (ignored when empty)
//             head       - current head entry (undefined when empty)
//             empty      - no entries stored
//             full       - DEPTH entries stored
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo
    import stop_capture_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] c_occ_full = OCC_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q,    occ_d;

    logic w_push_ok;
    logic w_pop_ok;

    assign empty = (occ_q == '0);
    assign full  = (occ_q == c_occ_full);
    assign head  = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves on the same edge:
    // the freed slot is the one the write pointer already points at.
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        if (w_push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({w_push_ok, w_pop_ok})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is intentionally left out of reset; the zero-mask on the read
    // side hides stale contents while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/stop_capture_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : stop_capture_fifo
//  Purpose  : Captures the upstream counter value on every rising edge of
//             the delayed stop pulse, queues it and hands it to a reader over
//             valid/ready. Flags dropped captures and keeps a saturating
//             total of all captures.
//  Ports    : clk         - clock, rising edge
//             reset       - synchronous active-high reset
//             count       - counter value from upstream
//             stop_d2     - delayed stop pulse from upstream
//             out_data    - FIFO head, 0 when empty
//             out_valid   - FIFO non-empty
//             out_ready   - reader accepts the head this cycle
//             full        - FIFO holds DEPTH entries
//             overflow    - sticky, a capture was dropped
//             capture_cnt - accepted plus dropped captures, saturating
//  Revision : 1.0  initial release
// ============================================================================
module stop_capture_fifo
    import stop_capture_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic             stop_d2,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             full,
    output logic             overflow,
    output logic [CNT_W-1:0] capture_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic             stop_q,     stop_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] cap_cnt_q,  cap_cnt_d;

    logic             w_cap;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [WIDTH-1:0] w_head;
    logic             w_empty;
    logic             w_full;

    // A stop pulse held high for several cycles yields a single capture.
    assign w_cap  = stop_d2 & ~stop_q;
    assign w_pop  = out_valid & out_ready;
    // Drop only when full and nothing leaves on the same edge.
    assign w_drop = w_cap & w_full & ~w_pop;
    assign w_push = w_cap & ~w_drop;

    always_comb begin
        stop_d     = stop_d2;
        overflow_d = overflow_q | w_drop;
        cap_cnt_d  = cap_cnt_q;
        if (w_cap && (cap_cnt_q != c_cnt_max)) begin
            cap_cnt_d = cap_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stop_q     <= 1'b0;
            overflow_q <= 1'b0;
            cap_cnt_q  <= '0;
        end else begin
            stop_q     <= stop_d;
            overflow_q <= overflow_d;
            cap_cnt_q  <= cap_cnt_d;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (count),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .full      (w_full)
    );

    assign out_valid   = ~w_empty;
    assign out_data    = w_empty ? '0 : w_head;
    assign full        = w_full;
    assign overflow    = overflow_q;
    assign capture_cnt = cap_cnt_q;

endmodule : stop_capture_fifo
`default_nettype wire
